// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider / segment symbol front end:
// default divide ratios, segment type and the active-low symbol table.
package clk_div_pkg;

    localparam int DEF_DIV_5M = 10;
    localparam int DEF_DIV_500 = 100000;
    localparam int DEF_DIV_50 = 1000000;
    localparam int DEF_DIV_5 = 10000000;
    localparam int DEF_DIV_1 = 50000000;
    localparam int DEF_DIV_05 = 100000000;

    typedef logic [6:0] seg_t;

    // Bit order a..g from bit6 down to bit0, segments lit when 0
    localparam seg_t SEG_SYM_0 = 7'b0000001;
    localparam seg_t SEG_SYM_1 = 7'b1001111;
    localparam seg_t SEG_SYM_2 = 7'b0010010;
    localparam seg_t SEG_SYM_3 = 7'b0000110;
    localparam seg_t SEG_SYM_4 = 7'b1001100;
    localparam seg_t SEG_SYM_5 = 7'b0100100;
    localparam seg_t SEG_SYM_6 = 7'b0100000;
    localparam seg_t SEG_SYM_7 = 7'b0001111;
    localparam seg_t SEG_BLANK = 7'b1111111;

    function automatic seg_t seg_decode(input logic [2:0] sym);
        seg_t pat;
        case (sym)
            3'd0: pat = SEG_SYM_0;
            3'd1: pat = SEG_SYM_1;
            3'd2: pat = SEG_SYM_2;
            3'd3: pat = SEG_SYM_3;
            3'd4: pat = SEG_SYM_4;
            3'd5: pat = SEG_SYM_5;
            3'd6: pat = SEG_SYM_6;
            default: pat = SEG_SYM_7;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: 50%-duty square wave with a period of DIV input
// cycles (DIV even, >= 2), output driven straight from a flop.
module clk_div_ch #(
    parameter int DIV = 10
) (
    input  logic CLK_50M,
    input  logic RST,
    output logic clk_out
);

    localparam int HALF = DIV / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            cnt <= '0;
            clk_out <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            clk_out <= ~clk_out;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clk_div_seg_sym.sv
// Six independent clock dividers plus a registered 3-bit to 7-segment decoder.
// Define SEG_ACTIVE_HIGH_EN for active-high segments (blank = 7'b0000000).
module clk_div_seg_sym
    import clk_div_pkg::*;
#(
    parameter int DIV_5M = DEF_DIV_5M,
    parameter int DIV_500 = DEF_DIV_500,
    parameter int DIV_50 = DEF_DIV_50,
    parameter int DIV_5 = DEF_DIV_5,
    parameter int DIV_1 = DEF_DIV_1,
    parameter int DIV_05 = DEF_DIV_05
) (
    input  logic       CLK_50M,
    input  logic       RST,
    input  logic [2:0] state,
    output logic       CLK_5M,
    output logic       CLK_500,
    output logic       CLK_50,
    output logic       CLK_5,
    output logic       CLK_1,
    output logic       CLK_05,
    output logic [6:0] s_to_d
);

    // Channels share one reset edge so their phases stay aligned
    clk_div_ch #(.DIV(DIV_5M)) u_ch_5m (.CLK_50M(CLK_50M), .RST(RST), .clk_out(CLK_5M));
    clk_div_ch #(.DIV(DIV_500)) u_ch_500 (.CLK_50M(CLK_50M), .RST(RST), .clk_out(CLK_500));
    clk_div_ch #(.DIV(DIV_50)) u_ch_50 (.CLK_50M(CLK_50M), .RST(RST), .clk_out(CLK_50));
    clk_div_ch #(.DIV(DIV_5)) u_ch_5 (.CLK_50M(CLK_50M), .RST(RST), .clk_out(CLK_5));
    clk_div_ch #(.DIV(DIV_1)) u_ch_1 (.CLK_50M(CLK_50M), .RST(RST), .clk_out(CLK_1));
    clk_div_ch #(.DIV(DIV_05)) u_ch_05 (.CLK_50M(CLK_50M), .RST(RST), .clk_out(CLK_05));

`ifdef SEG_ACTIVE_HIGH_EN
    localparam seg_t SEG_RESET = ~SEG_BLANK;
    localparam seg_t SEG_XOR = 7'b1111111;
`else
    localparam seg_t SEG_RESET = SEG_BLANK;
    localparam seg_t SEG_XOR = 7'b0000000;
`endif

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            s_to_d <= SEG_RESET;
        end else begin
            s_to_d <= seg_decode(state) ^ SEG_XOR;
        end
    end

endmodule

// File: tb/tb_clk_div_seg_sym.sv
// Scoreboard bench for clk_div_seg_sym with scaled divide ratios: random and
// swept symbols plus mid-run resets, checked against an arithmetic model.
module tb_clk_div_seg_sym;

    localparam int NCH = 6;

    typedef struct {
        logic [6:0] seg;
        int         n_edges;
    } exp_t;

    logic       clk_50m;
    logic       rst;
    logic [2:0] state;
    logic       clk_5m, clk_500, clk_50, clk_5, clk_1, clk_05;
    logic [6:0] s_to_d;

    int   vectors = 0;
    int   miscompares = 0;
    int   edges = 0;
    bit   checking = 0;
    exp_t sb[$];
    int   half_tab[NCH];
    logic [6:0] ref_tab[8];

    clk_div_seg_sym #(
        .DIV_5M(10), .DIV_500(4), .DIV_50(8), .DIV_5(12), .DIV_1(20), .DIV_05(40)
    ) dut (
        .CLK_50M(clk_50m), .RST(rst), .state(state),
        .CLK_5M(clk_5m), .CLK_500(clk_500), .CLK_50(clk_50),
        .CLK_5(clk_5), .CLK_1(clk_1), .CLK_05(clk_05),
        .s_to_d(s_to_d)
    );

    initial clk_50m = 1'b0;
    always #5 clk_50m = ~clk_50m;

    // An output is high during every odd-numbered block of H edges after release
    function automatic logic model_clk(input int n, input int h);
        return logic'((n / h) % 2);
    endfunction

    function automatic logic [6:0] model_seg(input logic [2:0] s);
`ifdef SEG_ACTIVE_HIGH_EN
        return ~ref_tab[s];
`else
        return ref_tab[s];
`endif
    endfunction

    function automatic logic [6:0] blank_seg();
`ifdef SEG_ACTIVE_HIGH_EN
        return 7'b0000000;
`else
        return 7'b1111111;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [6:0] actual, input logic [6:0] expected);
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
        end
    endtask

    // Called on a falling edge: drive a symbol and predict the next sample
    task automatic applyStimulus(input logic [2:0] s);
        exp_t e;
        state = s;
        e.seg = model_seg(s);
        e.n_edges = edges + 1;
        sb.push_back(e);
        @(negedge clk_50m);
        edges++;
    endtask

    task automatic checkReset();
        vectors++;
        checkOutput("rst_clocks", {1'b0, clk_5m, clk_500, clk_50, clk_5, clk_1, clk_05}, 7'b0);
        checkOutput("rst_seg", s_to_d, blank_seg());
    endtask

    task automatic releaseReset();
        @(negedge clk_50m);
        rst = 1'b0;
        edges = 0;
        checking = 1;
    endtask

    task automatic assertResetAsync();
        #2;
        rst = 1'b1;
        checking = 0;
        sb.delete();
        #1;
        checkReset();
    endtask

    // Monitor samples 1 ns after each rising edge, away from stimulus updates
    always @(posedge clk_50m) begin
        exp_t e;
        logic [NCH-1:0] act_clk;
        logic [NCH-1:0] exp_clk;
        #1;
        if (checking && sb.size() > 0) begin
            e = sb.pop_front();
            act_clk = {clk_5m, clk_500, clk_50, clk_5, clk_1, clk_05};
            for (int i = 0; i < NCH; i++)
                exp_clk[NCH-1-i] = model_clk(e.n_edges, half_tab[i]);
            vectors++;
            checkOutput("seg", s_to_d, e.seg);
            checkOutput("clocks", {1'b0, act_clk}, {1'b0, exp_clk});
        end
    end

    initial begin
        int guard;
        half_tab = '{5, 2, 4, 6, 10, 20};
        ref_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};
        rst = 1'b1;
        state = 3'd0;
        repeat (3) @(negedge clk_50m);
        checkReset();

        releaseReset();
        for (int i = 0; i < 8; i++) applyStimulus(3'(i));
        repeat (300) applyStimulus(3'($urandom_range(0, 7)));

        // Reset while the slow CLK_1 output is high, held for three cycles
        for (int r = 0; r < 3; r++) begin
            guard = 0;
            while (!model_clk(edges, 10) && guard < 40) begin
                applyStimulus(3'($urandom_range(0, 7)));
                guard++;
            end
            assertResetAsync();
            repeat (3) @(negedge clk_50m);
            checkReset();
            releaseReset();
            repeat (120 + $urandom_range(0, 50)) applyStimulus(3'($urandom_range(0, 7)));
        end

        for (int i = 7; i >= 0; i--) applyStimulus(3'(i));
        repeat (2) @(negedge clk_50m);
        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
